regfile: RTL and testbench

Parametrised general-purpose register file for the EDiC datapath, succeeding the fixed two-register set. Holds `DEPTH` registers of `WIDTH` bits with per-register reset values. Provides one synchronous write port, one synchronous increment/decrement port with wrap flag, two combinational ALU read ports and one tri-stated bus read port. Sits between the data bus, the ALU operand muxes and the control unit.

---
 rtl/regfile.sv | 114 +++++++++++
 tb/tb_regfile.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Parametrised register file: one write port, one inc/dec port with wrap flag, two ALU read ports, one tri-stated bus port.
// Define REGFILE_BYPASS_EN to forward same-cycle write/inc-dec results onto the ALU read ports.

module transmitter #(
  parameter int WIDTH = 8
) (
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  assign q = en ? d : {WIDTH{1'bz}};

endmodule

module regfile #(
  parameter int                     WIDTH      = 8,
  parameter int                     DEPTH      = 4,
  parameter logic [DEPTH*WIDTH-1:0] RESET_VALS = {8'd0, 8'd0, 8'd5, 8'd0},
  localparam int                    AW         = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_wrEn,
  input  logic [AW-1:0]    i_wrSel,
  input  logic             i_incEn,
  input  logic [AW-1:0]    i_incSel,
  input  logic             i_dec,
  output logic             o_wrap,
  input  logic [AW-1:0]    i_aluSelA,
  output logic [WIDTH-1:0] o_aluA,
  input  logic [AW-1:0]    i_aluSelB,
  output logic [WIDTH-1:0] o_aluB,
  input  logic [AW-1:0]    i_busSel,
  input  logic             i_busEn,
  output logic [WIDTH-1:0] o_bus
);

  logic [WIDTH-1:0] regs [DEPTH];

  logic [WIDTH-1:0] inc_cur;
  logic [WIDTH-1:0] inc_next;
  logic             inc_wraps;
  logic             collide;
  logic             inc_live;

  assign inc_cur   = regs[i_incSel];
  assign inc_next  = i_dec ? inc_cur - WIDTH'(1) : inc_cur + WIDTH'(1);
  assign inc_wraps = i_dec ? (inc_cur == '0) : (inc_cur == '1);

  // A write to the same register as the inc/dec wins and cancels it.
  assign collide  = i_wrEn && i_incEn && (i_wrSel == i_incSel);
  assign inc_live = i_incEn && !collide;

  for (genvar k = 0; k < DEPTH; k++) begin : g_reg
    logic wr_hit;
    logic inc_hit;

    assign wr_hit  = i_wrEn && (i_wrSel == AW'(k));
    assign inc_hit = inc_live && (i_incSel == AW'(k));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        regs[k] <= RESET_VALS[k*WIDTH +: WIDTH];
      end else if (wr_hit) begin
        regs[k] <= i_d;
      end else if (inc_hit) begin
        regs[k] <= inc_next;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wrap <= 1'b0;
    end else if (i_incEn) begin
      o_wrap <= inc_live && inc_wraps;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Write data takes precedence over the inc/dec result, mirroring the collision rule.
  always_comb begin
    o_aluA = regs[i_aluSelA];
    if (i_wrEn && (i_wrSel == i_aluSelA)) begin
      o_aluA = i_d;
    end else if (i_incEn && (i_incSel == i_aluSelA)) begin
      o_aluA = inc_next;
    end
  end

  always_comb begin
    o_aluB = regs[i_aluSelB];
    if (i_wrEn && (i_wrSel == i_aluSelB)) begin
      o_aluB = i_d;
    end else if (i_incEn && (i_incSel == i_aluSelB)) begin
      o_aluB = inc_next;
    end
  end
`else
  assign o_aluA = regs[i_aluSelA];
  assign o_aluB = regs[i_aluSelB];
`endif

  transmitter #(
    .WIDTH(WIDTH)
  ) u_transmitter (
    .en(i_busEn),
    .d (regs[i_busSel]),
    .q (o_bus)
  );

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: default 8x4 instance plus a 16x8 instance,
// checked every cycle against an array model and pinned with literal expectations.

module tb_regfile;

  localparam logic [31:0]  RV_A = {8'd0, 8'd0, 8'd5, 8'd0};
  localparam logic [127:0] RV_B = {16'h1234, 16'h0007, 16'h0000, 16'hABCD,
                                   16'h0000, 16'h0042, 16'hFFFF, 16'h0001};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 8-bit x 4 instance
  logic       rst_a_n = 1'b1;
  logic [7:0] d = '0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_sel = '0;
  logic       inc_en = 1'b0;
  logic [1:0] inc_sel = '0;
  logic       dec = 1'b0;
  logic       wrap;
  logic [1:0] sel_a = '0;
  logic [7:0] alu_a;
  logic [1:0] sel_b = '0;
  logic [7:0] alu_b;
  logic [1:0] bus_sel = '0;
  logic       bus_en = 1'b0;
  wire  [7:0] bus_a;

  // 16-bit x 8 instance
  logic        rst_b_n = 1'b1;
  logic [15:0] b_d = '0;
  logic        b_wr_en = 1'b0;
  logic [2:0]  b_wr_sel = '0;
  logic        b_inc_en = 1'b0;
  logic [2:0]  b_inc_sel = '0;
  logic        b_dec = 1'b0;
  logic        b_wrap;
  logic [2:0]  b_sel_a = '0;
  logic [15:0] b_alu_a;
  logic [2:0]  b_sel_b = '0;
  logic [15:0] b_alu_b;
  logic [2:0]  b_bus_sel = '0;
  logic        b_bus_en = 1'b0;
  wire  [15:0] bus_b;

  regfile dut_a (
    .i_clk(clk), .i_reset_n(rst_a_n), .i_d(d), .i_wrEn(wr_en), .i_wrSel(wr_sel),
    .i_incEn(inc_en), .i_incSel(inc_sel), .i_dec(dec), .o_wrap(wrap),
    .i_aluSelA(sel_a), .o_aluA(alu_a), .i_aluSelB(sel_b), .o_aluB(alu_b),
    .i_busSel(bus_sel), .i_busEn(bus_en), .o_bus(bus_a)
  );

  regfile #(.WIDTH(16), .DEPTH(8), .RESET_VALS(RV_B)) dut_b (
    .i_clk(clk), .i_reset_n(rst_b_n), .i_d(b_d), .i_wrEn(b_wr_en), .i_wrSel(b_wr_sel),
    .i_incEn(b_inc_en), .i_incSel(b_inc_sel), .i_dec(b_dec), .o_wrap(b_wrap),
    .i_aluSelA(b_sel_a), .o_aluA(b_alu_a), .i_aluSelB(b_sel_b), .o_aluB(b_alu_b),
    .i_busSel(b_bus_sel), .i_busEn(b_bus_en), .o_bus(bus_b)
  );

  // Reference model: plain arrays updated by the architectural rules.
  logic [7:0]  mdl_a [4];
  logic        mdl_wrap;
  logic [15:0] mdl_b [8];

  always @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      for (int k = 0; k < 4; k++) mdl_a[k] <= RV_A[k*8 +: 8];
      mdl_wrap <= 1'b0;
    end else begin
      if (inc_en) begin
        if (wr_en && wr_sel == inc_sel) begin
          mdl_wrap <= 1'b0;
        end else begin
          mdl_a[inc_sel] <= 8'((int'(mdl_a[inc_sel]) + (dec ? 255 : 1)) % 256);
          mdl_wrap <= dec ? (int'(mdl_a[inc_sel]) == 0) : (int'(mdl_a[inc_sel]) == 255);
        end
      end
      if (wr_en) mdl_a[wr_sel] <= d;
    end
  end

  always @(posedge clk or negedge rst_b_n) begin
    if (!rst_b_n) begin
      for (int k = 0; k < 8; k++) mdl_b[k] <= RV_B[k*16 +: 16];
    end else if (b_wr_en) begin
      mdl_b[b_wr_sel] <= b_d;
    end
  end

  function automatic logic [7:0] expA(input logic [1:0] s);
    logic [7:0] v;
    v = mdl_a[s];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_sel == s) v = d;
    else if (inc_en && inc_sel == s) v = 8'((int'(v) + (dec ? 255 : 1)) % 256);
`endif
    return v;
  endfunction

  function automatic logic [15:0] expB(input logic [2:0] s);
    logic [15:0] v;
    v = mdl_b[s];
`ifdef REGFILE_BYPASS_EN
    if (b_wr_en && b_wr_sel == s) v = b_d;
`endif
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A released bus must not show the selected register's (nonzero) contents.
  task automatic checkReleased(input string name, input logic [15:0] act, input logic [15:0] driven);
    tests++;
    if (act === driven) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected high-Z (not %h)", name, act, driven);
    end
  endtask

  always @(negedge clk) begin
    if (rst_a_n) begin
      checkOutput("cmp_alu_a", 16'(alu_a), 16'(expA(sel_a)));
      checkOutput("cmp_alu_b", 16'(alu_b), 16'(expA(sel_b)));
      checkOutput("cmp_wrap", 16'(wrap), 16'(mdl_wrap));
      if (bus_en) checkOutput("cmp_bus_a", 16'(bus_a), 16'(mdl_a[bus_sel]));
      else if (mdl_a[bus_sel] != 8'h00) checkReleased("cmp_bus_a_z", 16'(bus_a), 16'(mdl_a[bus_sel]));
    end
    if (rst_b_n) begin
      checkOutput("cmp_b_alu_a", b_alu_a, expB(b_sel_a));
      checkOutput("cmp_b_alu_b", b_alu_b, expB(b_sel_b));
      checkOutput("cmp_b_wrap", 16'(b_wrap), 16'h0);
      if (b_bus_en) checkOutput("cmp_bus_b", bus_b, mdl_b[b_bus_sel]);
    end
  end

  // Drive one cycle of write/inc-dec on the 8-bit instance, then return to idle.
  task automatic applyStimulus(input logic we, input logic [1:0] ws, input logic [7:0] wd,
                               input logic ie, input logic [1:0] is, input logic dc);
    wr_en = we; wr_sel = ws; d = wd;
    inc_en = ie; inc_sel = is; dec = dc;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    inc_en = 1'b0;
  endtask

  initial begin
    #1;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    #1;
    sel_a = 2'd0; sel_b = 2'd1; bus_sel = 2'd1; bus_en = 1'b0;
    b_sel_a = 3'd7; b_sel_b = 3'd1;
    #1;
    checkOutput("rst_reg0", 16'(alu_a), 16'h00);
    checkOutput("rst_reg1", 16'(alu_b), 16'h05);
    checkOutput("rst_wrap", 16'(wrap), 16'h0);
    checkReleased("rst_bus_z", 16'(bus_a), 16'h05);
    checkOutput("rst_b_reg7", b_alu_a, 16'h1234);
    checkOutput("rst_b_reg1", b_alu_b, 16'hFFFF);
    sel_a = 2'd2; sel_b = 2'd3;
    #1;
    checkOutput("rst_reg2", 16'(alu_a), 16'h00);
    checkOutput("rst_reg3", 16'(alu_b), 16'h00);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 1'b0);
    sel_a = 2'd2; sel_b = 2'd1; bus_sel = 2'd2; bus_en = 1'b1;
    #1;
    checkOutput("wr_alu_a", 16'(alu_a), 16'hA5);
    checkOutput("wr_alu_b", 16'(alu_b), 16'h05);
    checkOutput("wr_bus", 16'(bus_a), 16'hA5);
    bus_en = 1'b0;

    sel_a = 2'd3;
    applyStimulus(1'b1, 2'd3, 8'hFF, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0);
    checkOutput("inc_wrap_val", 16'(alu_a), 16'h00);
    checkOutput("inc_wrap_flag", 16'(wrap), 16'h1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1);
    checkOutput("dec_wrap_val", 16'(alu_a), 16'hFF);
    checkOutput("dec_wrap_flag", 16'(wrap), 16'h1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1);
    checkOutput("dec_val", 16'(alu_a), 16'hFE);
    checkOutput("dec_flag", 16'(wrap), 16'h0);

    applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1);
    applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    checkOutput("wrap_hold", 16'(wrap), 16'h1);
    sel_a = 2'd1; sel_b = 2'd0;
    applyStimulus(1'b1, 2'd1, 8'h10, 1'b1, 2'd1, 1'b0);
    checkOutput("coll_val", 16'(alu_a), 16'h10);
    checkOutput("coll_wrap", 16'(wrap), 16'h0);
    checkOutput("coll_other", 16'(alu_b), 16'hFF);

    // Reset lands mid-write: the write must be lost.
    wr_en = 1'b1; wr_sel = 2'd2; d = 8'h77; sel_a = 2'd2;
    #2;
    rst_a_n = 1'b0;
    #1;
    checkOutput("rst_mid_async", 16'(alu_a), 16'h00);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rst_a_n = 1'b1;
    #1;
    checkOutput("rst_mid_nowrite", 16'(alu_a), 16'h00);
    @(posedge clk);
    #1;

    sel_a = 2'd0; sel_b = 2'd1;
    applyStimulus(1'b1, 2'd0, 8'h10, 1'b1, 2'd1, 1'b0);
    checkOutput("diff_wr", 16'(alu_a), 16'h10);
    checkOutput("diff_inc", 16'(alu_b), 16'h06);

    wr_en = 1'b1; wr_sel = 2'd0; d = 8'h3C; sel_a = 2'd0;
    inc_en = 1'b1; inc_sel = 2'd1; dec = 1'b1; sel_b = 2'd1;
    #1;
`ifdef REGFILE_BYPASS_EN
    checkOutput("byp_wr_pre", 16'(alu_a), 16'h3C);
    checkOutput("byp_inc_pre", 16'(alu_b), 16'h05);
`else
    checkOutput("byp_wr_pre", 16'(alu_a), 16'h10);
    checkOutput("byp_inc_pre", 16'(alu_b), 16'h06);
`endif
    @(posedge clk);
    #1;
    wr_en = 1'b0; inc_en = 1'b0;
    checkOutput("byp_wr_post", 16'(alu_a), 16'h3C);
    checkOutput("byp_inc_post", 16'(alu_b), 16'h05);

    // Sweep: writes, inc/dec on a neighbour, both ALU ports on one register.
    for (int i = 0; i < 8; i++) begin
      sel_a = 2'(i); sel_b = 2'(i); bus_sel = 2'(i + 1); bus_en = i[0];
      applyStimulus(i[1], 2'(i), 8'(i * 8'h55 + 8'hFD), 1'b1, 2'(i + 1), i[2]);
    end
    bus_en = 1'b0;

    b_wr_en = 1'b1; b_wr_sel = 3'd7; b_d = 16'hBEEF;
    @(posedge clk);
    #1;
    b_wr_en = 1'b0;
    b_sel_a = 3'd7; b_sel_b = 3'd7; b_bus_sel = 3'd7; b_bus_en = 1'b1;
    #1;
    checkOutput("b_wr_a", b_alu_a, 16'hBEEF);
    checkOutput("b_wr_b", b_alu_b, 16'hBEEF);
    checkOutput("b_wr_bus", bus_b, 16'hBEEF);
    b_wr_en = 1'b1; b_d = 16'h5555;
    #2;
    rst_b_n = 1'b0;
    #1;
    checkOutput("b_rst_async", b_alu_a, 16'h1234);
    @(posedge clk);
    #1;
    b_wr_en = 1'b0;
    rst_b_n = 1'b1;
    #1;
    checkOutput("b_rst_a", b_alu_a, 16'h1234);
    checkOutput("b_rst_bus", bus_b, 16'h1234);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
